grid_click_decoder: RTL and testbench

- Parametrised screen-to-grid hit tester for the mouse-driven game boards.
- Maps registered mouse coordinates to a (column, row) cell on a ROWS x COLS grid with configurable origin, cell size and pitch, and reports the hovered cell with an explicit hit flag; gaps and off-grid positions count as misses.
- Tracks the mouse button. A click event is emitted only when the press and the release land on the same hit cell.
- Click events leave through a valid/ready handshake toward the game controller.

---
 rtl/grid_click_pkg.sv | 19 +
 rtl/grid_axis_decoder.sv | 38 +++
 rtl/grid_click_decoder.sv | 196 +++++++++++++++++++
 tb/tb_grid_click_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/grid_click_pkg.sv
// Shared types and default board geometry for the grid click decoder.
package grid_click_pkg;

  // Click tracking states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_IGNORE = 2'd2
  } state_e;

  // Default geometry for the 8x8 board, in pixels.
  localparam int DEF_X_ORIGIN = 17;
  localparam int DEF_Y_ORIGIN = 8;
  localparam int DEF_CELL_W   = 20;
  localparam int DEF_CELL_H   = 20;
  localparam int DEF_PITCH_X  = 37;
  localparam int DEF_PITCH_Y  = 28;

endpackage

// File: rtl/grid_axis_decoder.sv
// Combinational single-axis hit test: finds which of N cells (if any) holds pos.
// Bounds are elaboration-time constants, one bit wider than pos, so no
// runtime multiply or divide is needed.
module grid_axis_decoder #(
  parameter int N      = 8,
  parameter int W      = 10,
  parameter int ORIGIN = 17,
  parameter int CELL   = 20,
  parameter int PITCH  = 37,
  parameter int IW     = 3
) (
  input  logic [W-1:0]  pos,
  output logic [IW-1:0] idx,
  output logic          hit
);

  logic [W:0]   pos_ext;
  logic [N-1:0] cell_hit;

  assign pos_ext = {1'b0, pos};

  for (genvar c = 0; c < N; c++) begin : g_cell
    localparam logic [W:0] LO = (W+1)'(ORIGIN + c * PITCH);
    localparam logic [W:0] HI = (W+1)'(ORIGIN + c * PITCH + CELL - 1);
    assign cell_hit[c] = (pos_ext >= LO) && (pos_ext <= HI);
  end

  // Encode the (at most one) hitting cell; cells never overlap, so OR-ing is exact.
  always_comb begin
    idx = {IW{1'b0}};
    hit = 1'b0;
    for (int c = 0; c < N; c++) begin
      idx = idx | ({IW{cell_hit[c]}} & IW'(c));
      hit = hit | cell_hit[c];
    end
  end

endmodule

// File: rtl/grid_click_decoder.sv
// Screen-to-grid hit tester: registered hover cell plus a click event
// (press and release on the same cell) delivered over valid/ready.
module grid_click_decoder
  import grid_click_pkg::*;
#(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int X_ORIGIN = DEF_X_ORIGIN,
  parameter int Y_ORIGIN = DEF_Y_ORIGIN,
  parameter int CELL_W   = DEF_CELL_W,
  parameter int CELL_H   = DEF_CELL_H,
  parameter int PITCH_X  = DEF_PITCH_X,
  parameter int PITCH_Y  = DEF_PITCH_Y,
  parameter int CW       = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          iReset,
  input  logic [XW-1:0] iMouseX,
  input  logic [YW-1:0] iMouseY,
  input  logic          iButton,
  input  logic          iEnable,
  output logic [CW-1:0] oHoverX,
  output logic [RW-1:0] oHoverY,
  output logic          oHoverHit,
  output logic          oClickValid,
  input  logic          iClickReady,
  output logic [CW-1:0] oClickX,
  output logic [RW-1:0] oClickY,
  output logic          oDropped
);

  // Stage 1: raw inputs.
  logic [XW-1:0] mouse_x_q, mouse_x_d;
  logic [YW-1:0] mouse_y_q, mouse_y_d;
  logic          btn1_q, btn1_d;
  // Stage 2: decode results and delayed button; btn3 is btn2's previous value.
  logic [CW-1:0] hover_x_q, hover_x_d;
  logic [RW-1:0] hover_y_q, hover_y_d;
  logic          hover_hit_q, hover_hit_d;
  logic          btn2_q, btn2_d;
  logic          btn3_q, btn3_d;
  // FSM and latched press cell.
  state_e        state_q, state_d;
  logic [CW-1:0] latch_x_q, latch_x_d;
  logic [RW-1:0] latch_y_q, latch_y_d;
  // Output event register.
  logic          valid_q, valid_d;
  logic [CW-1:0] click_x_q, click_x_d;
  logic [RW-1:0] click_y_q, click_y_d;
  logic          dropped_q, dropped_d;

  logic [CW-1:0] dec_x_idx;
  logic [RW-1:0] dec_y_idx;
  logic          dec_x_hit, dec_y_hit;
  logic          rise, fall, emit;

  grid_axis_decoder #(
    .N(COLS), .W(XW), .ORIGIN(X_ORIGIN), .CELL(CELL_W), .PITCH(PITCH_X), .IW(CW)
  ) u_dec_x (
    .pos(mouse_x_q), .idx(dec_x_idx), .hit(dec_x_hit)
  );

  grid_axis_decoder #(
    .N(ROWS), .W(YW), .ORIGIN(Y_ORIGIN), .CELL(CELL_H), .PITCH(PITCH_Y), .IW(RW)
  ) u_dec_y (
    .pos(mouse_y_q), .idx(dec_y_idx), .hit(dec_y_hit)
  );

  assign rise = btn2_q & ~btn3_q;
  assign fall = ~btn2_q & btn3_q;

  // Two-stage input/decode pipeline next values.
  always_comb begin
    mouse_x_d   = iMouseX;
    mouse_y_d   = iMouseY;
    btn1_d      = iButton;
    hover_x_d   = dec_x_idx;
    hover_y_d   = dec_y_idx;
    hover_hit_d = dec_x_hit & dec_y_hit;
    btn2_d      = btn1_q;
    btn3_d      = btn2_q;
  end

  // Click FSM: arm on a press over a cell, fire on release over the same cell.
  always_comb begin
    state_d   = state_q;
    latch_x_d = latch_x_q;
    latch_y_d = latch_y_q;
    emit      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          if (hover_hit_q && iEnable) begin
            latch_x_d = hover_x_q;
            latch_y_d = hover_y_q;
            state_d   = S_ARMED;
          end else begin
            state_d   = S_IGNORE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (fall) begin
          emit    = hover_hit_q && (hover_x_q == latch_x_q) && (hover_y_q == latch_y_q);
          state_d = S_IDLE;
        end else if (!iEnable) begin
          state_d = S_IGNORE;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_IGNORE: begin
        if (fall) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_IGNORE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output handshake: load on emit when free or being accepted, else drop and flag.
  always_comb begin
    valid_d   = valid_q;
    click_x_d = click_x_q;
    click_y_d = click_y_q;
    dropped_d = dropped_q;
    if (emit) begin
      if (!valid_q || iClickReady) begin
        valid_d   = 1'b1;
        click_x_d = latch_x_q;
        click_y_d = latch_y_q;
      end else begin
        dropped_d = 1'b1;
      end
    end else if (valid_q && iClickReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (iReset) begin
      mouse_x_q   <= {XW{1'b0}};
      mouse_y_q   <= {YW{1'b0}};
      btn1_q      <= 1'b0;
      hover_x_q   <= {CW{1'b0}};
      hover_y_q   <= {RW{1'b0}};
      hover_hit_q <= 1'b0;
      btn2_q      <= 1'b0;
      btn3_q      <= 1'b0;
      state_q     <= S_IDLE;
      latch_x_q   <= {CW{1'b0}};
      latch_y_q   <= {RW{1'b0}};
      valid_q     <= 1'b0;
      click_x_q   <= {CW{1'b0}};
      click_y_q   <= {RW{1'b0}};
      dropped_q   <= 1'b0;
    end else begin
      mouse_x_q   <= mouse_x_d;
      mouse_y_q   <= mouse_y_d;
      btn1_q      <= btn1_d;
      hover_x_q   <= hover_x_d;
      hover_y_q   <= hover_y_d;
      hover_hit_q <= hover_hit_d;
      btn2_q      <= btn2_d;
      btn3_q      <= btn3_d;
      state_q     <= state_d;
      latch_x_q   <= latch_x_d;
      latch_y_q   <= latch_y_d;
      valid_q     <= valid_d;
      click_x_q   <= click_x_d;
      click_y_q   <= click_y_d;
      dropped_q   <= dropped_d;
    end
  end

  assign oHoverX     = hover_x_q;
  assign oHoverY     = hover_y_q;
  assign oHoverHit   = hover_hit_q;
  assign oClickValid = valid_q;
  assign oClickX     = click_x_q;
  assign oClickY     = click_y_q;
  assign oDropped    = dropped_q;

endmodule

// File: tb/tb_grid_click_decoder.sv
// Directed bench for grid_click_decoder: hover sweep, clicks, drags,
// back-pressure, enable handling and reset abort, with a click scoreboard.
module tb_grid_click_decoder;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } ev_t;

  logic       clk = 1'b0;
  logic       iReset;
  logic [9:0] iMouseX;
  logic [8:0] iMouseY;
  logic       iButton;
  logic       iEnable;
  logic [2:0] oHoverX;
  logic [2:0] oHoverY;
  logic       oHoverHit;
  logic       oClickValid;
  logic       iClickReady;
  logic [2:0] oClickX;
  logic [2:0] oClickY;
  logic       oDropped;

  int  total = 0;
  int  bad   = 0;
  ev_t sb_q[$];

  grid_click_decoder dut (
    .clk(clk), .iReset(iReset), .iMouseX(iMouseX), .iMouseY(iMouseY),
    .iButton(iButton), .iEnable(iEnable), .oHoverX(oHoverX), .oHoverY(oHoverY),
    .oHoverHit(oHoverHit), .oClickValid(oClickValid), .iClickReady(iClickReady),
    .oClickX(oClickX), .oClickY(oClickY), .oDropped(oDropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mouse(input int x, input int y);
    iMouseX = 10'(x);
    iMouseY = 9'(y);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_hx"},  32'(oHoverX), 32'd0);
    chk({tag, "_hy"},  32'(oHoverY), 32'd0);
    chk({tag, "_hit"}, 32'(oHoverHit), 32'd0);
    chk({tag, "_vld"}, 32'(oClickValid), 32'd0);
    chk({tag, "_cx"},  32'(oClickX), 32'd0);
    chk({tag, "_cy"},  32'(oClickY), 32'd0);
    chk({tag, "_drp"}, 32'(oDropped), 32'd0);
  endtask

  // Scoreboard: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (!iReset && oClickValid && iClickReady) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_event", 32'(sb_q.size()), 32'd1);
      end else begin
        ev_t e;
        e = sb_q.pop_front();
        chk("sb_click_x", 32'(oClickX), 32'(e.x));
        chk("sb_click_y", 32'(oClickY), 32'(e.y));
      end
    end
  end

  // Hover sweep table: x, y, expected column, row, hit.
  int hx_t[11]  = '{17, 36, 37, 54, 295, 296, 17, 17, 16, 37, 60};
  int hy_t[11]  = '{ 8,  8,  8,  8,   8,   8, 223, 224, 7, 40, 40};
  int ec_t[11]  = '{ 0,  0,  0,  1,   7,   0,  0,  0,  0,  0,  1};
  int er_t[11]  = '{ 0,  0,  0,  0,   0,   0,  7,  0,  0,  1,  1};
  int eh_t[11]  = '{ 1,  1,  0,  1,   1,   0,  1,  0,  0,  0,  1};

  initial begin
    iReset = 1'b1; iButton = 1'b0; iEnable = 1'b1; iClickReady = 1'b1;
    set_mouse(0, 0);

    // Reset state.
    tick(2);
    check_all_zero("reset");
    iReset = 1'b0;

    // Hover sweep, two-cycle latency.
    for (int i = 0; i < 11; i++) begin
      set_mouse(hx_t[i], hy_t[i]);
      tick(2);
      chk($sformatf("hover_x_%0d", i), 32'(oHoverX), 32'(ec_t[i]));
      chk($sformatf("hover_y_%0d", i), 32'(oHoverY), 32'(er_t[i]));
      chk($sformatf("hover_hit_%0d", i), 32'(oHoverHit), 32'(eh_t[i]));
    end

    // Basic click at (60,40) -> cell (1,1), three cycles after release.
    set_mouse(60, 40);
    iButton = 1'b1;
    tick(6);
    sb_q.push_back('{x: 3'd1, y: 3'd1});
    iButton = 1'b0;
    tick(2);
    chk("click_not_early", 32'(oClickValid), 32'd0);
    tick(1);
    chk("click_valid", 32'(oClickValid), 32'd1);
    chk("click_x", 32'(oClickX), 32'd1);
    chk("click_y", 32'(oClickY), 32'd1);
    tick(1);
    chk("click_pulse_end", 32'(oClickValid), 32'd0);

    // Drag to another cell: no event.
    iButton = 1'b1;
    tick(4);
    set_mouse(100, 40);
    tick(1);
    iButton = 1'b0;
    tick(6);
    chk("drag_no_event", 32'(oClickValid), 32'd0);

    // Press on a gap pixel, release on a cell: no event.
    set_mouse(40, 40);
    iButton = 1'b1;
    tick(4);
    set_mouse(60, 40);
    tick(2);
    iButton = 1'b0;
    tick(6);
    chk("gap_no_event", 32'(oClickValid), 32'd0);

    // Back-pressure: (1,1) held, (3,2) dropped.
    iClickReady = 1'b0;
    set_mouse(60, 40);
    iButton = 1'b1;
    tick(4);
    iButton = 1'b0;
    tick(4);
    chk("bp_first_valid", 32'(oClickValid), 32'd1);
    chk("bp_no_drop_yet", 32'(oDropped), 32'd0);
    set_mouse(130, 70);
    iButton = 1'b1;
    tick(4);
    iButton = 1'b0;
    tick(5);
    chk("bp_held_valid", 32'(oClickValid), 32'd1);
    chk("bp_held_x", 32'(oClickX), 32'd1);
    chk("bp_held_y", 32'(oClickY), 32'd1);
    chk("bp_dropped", 32'(oDropped), 32'd1);
    sb_q.push_back('{x: 3'd1, y: 3'd1});
    iClickReady = 1'b1;
    tick(1);
    chk("bp_accepted", 32'(oClickValid), 32'd0);
    tick(5);
    chk("bp_second_never", 32'(oClickValid), 32'd0);
    chk("bp_drop_sticky", 32'(oDropped), 32'd1);

    // iEnable dropped mid-hold over (2,2), restored before release: no event.
    set_mouse(95, 70);
    iButton = 1'b1;
    tick(4);
    iEnable = 1'b0;
    tick(2);
    iEnable = 1'b1;
    tick(2);
    iButton = 1'b0;
    tick(6);
    chk("en_drop_no_event", 32'(oClickValid), 32'd0);

    // Press while disabled, enable before release: no event.
    iEnable = 1'b0;
    iButton = 1'b1;
    tick(4);
    iEnable = 1'b1;
    tick(1);
    iButton = 1'b0;
    tick(6);
    chk("en_low_no_event", 32'(oClickValid), 32'd0);

    // Reset while armed with a pending event.
    iClickReady = 1'b0;
    set_mouse(60, 40);
    iButton = 1'b1;
    tick(4);
    iButton = 1'b0;
    tick(4);
    chk("rst_pending_valid", 32'(oClickValid), 32'd1);
    iButton = 1'b1;
    tick(4);
    iReset = 1'b1;
    tick(1);
    check_all_zero("rst_armed");
    iButton = 1'b0;
    tick(2);
    iReset = 1'b0;
    iClickReady = 1'b1;
    tick(8);
    chk("rst_no_event", 32'(oClickValid), 32'd0);
    chk("rst_hover_back", 32'(oHoverHit), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
